// File: rtl/arcade_pkg.sv
// Shared definitions for the arcade ROM loader: loader FSM states and the
// default core reset hold count.
package arcade_pkg;

    typedef enum logic [0:0] {
        LD_IDLE = 1'b0,
        LD_WAIT = 1'b1
    } ld_state_e;

    localparam logic [15:0] DEFAULT_RESET_HOLD = 16'hffff;

endpackage

// File: rtl/reset_hold_ctr.sv
// Core reset generator: reloads while held, otherwise counts down to zero and
// keeps core_reset asserted until the count has expired.
module reset_hold_ctr
    import arcade_pkg::*;
#(
    parameter int unsigned             HOLD_W     = 16,
    parameter logic [HOLD_W-1:0]       RESET_HOLD = HOLD_W'(DEFAULT_RESET_HOLD)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic hold_i,
    output logic core_reset_o
);

    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              core_reset_q;

    always_comb begin
        cnt_d = cnt_q;
        if (hold_i) begin
            cnt_d = RESET_HOLD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - HOLD_W'(1);
        end
    end

    // hold_i asserts reset on the same edge it reloads the counter, so a
    // one-cycle request still yields RESET_HOLD+1 cycles of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= RESET_HOLD;
            core_reset_q <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            core_reset_q <= hold_i || (cnt_q != '0);
        end
    end

    assign core_reset_o = core_reset_q;

endmodule

// File: rtl/arcade_rom_loader.sv
// ROM download controller: packs data_io bytes into 16-bit SDRAM writes,
// broadcasts them to toggle-handshake ports and generates the core reset.
module arcade_rom_loader
    import arcade_pkg::*;
#(
    parameter int unsigned       NUM_PORTS  = 2,
    parameter int unsigned       ADDR_W     = 24,
    parameter logic [7:0]        ROM_INDEX  = 8'd0,
    parameter int unsigned       HOLD_W     = 16,
    parameter logic [HOLD_W-1:0] RESET_HOLD = HOLD_W'(DEFAULT_RESET_HOLD)
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ioctl_downl,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_wr,
    input  logic [ADDR_W-1:0]    ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic                 ioctl_wait,
    output logic [NUM_PORTS-1:0] port_req,
    input  logic [NUM_PORTS-1:0] port_ack,
    output logic [ADDR_W-2:0]    port_a,
    output logic [1:0]           port_ds,
    output logic [15:0]          port_d,
    output logic                 port_we,
    input  logic                 reset_req,
    output logic                 core_reset,
    output logic                 rom_loaded,
    output logic                 overflow
);

    logic index_match;
    logic match;

    logic              wr_last_q;
    logic              downl_last_q;
    logic              strb_q;
    logic [ADDR_W-1:0] strb_addr_q;
    logic [7:0]        strb_data_q;

    logic              slot_full_q;
    logic [ADDR_W-1:0] slot_addr_q;
    logic [7:0]        slot_data_q;

    ld_state_e             state_q;
    logic [NUM_PORTS-1:0]  pending_q;
    logic [NUM_PORTS-1:0]  req_q;
    logic [ADDR_W-2:0]     a_q;
    logic [1:0]            ds_q;
    logic [15:0]           d_q;
    logic                  we_q;
    logic                  overflow_q;
    logic                  loaded_q;

    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic [7:0]        issue_data;

    assign index_match = (ioctl_index == ROM_INDEX);
    assign match       = ioctl_downl && index_match;

    // A held byte always takes priority over a freshly detected strobe.
    always_comb begin
        issue_en   = 1'b0;
        issue_addr = strb_addr_q;
        issue_data = strb_data_q;
        if (state_q == LD_IDLE) begin
            issue_en = strb_q;
        end else if (pending_q == '0) begin
            if (slot_full_q) begin
                issue_en   = 1'b1;
                issue_addr = slot_addr_q;
                issue_data = slot_data_q;
            end else begin
                issue_en = strb_q;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_last_q    <= 1'b0;
            downl_last_q <= 1'b0;
            strb_q       <= 1'b0;
            strb_addr_q  <= '0;
            strb_data_q  <= '0;
            slot_full_q  <= 1'b0;
            slot_addr_q  <= '0;
            slot_data_q  <= '0;
            state_q      <= LD_IDLE;
            pending_q    <= '0;
            req_q        <= '0;
            a_q          <= '0;
            ds_q         <= '0;
            d_q          <= '0;
            we_q         <= 1'b0;
            overflow_q   <= 1'b0;
            loaded_q     <= 1'b0;
        end else begin
            wr_last_q    <= ioctl_wr;
            downl_last_q <= ioctl_downl;
            we_q         <= match;
            strb_q       <= match && ioctl_wr && !wr_last_q;
            strb_addr_q  <= ioctl_addr;
            strb_data_q  <= ioctl_dout;

            if (downl_last_q && !ioctl_downl && index_match) begin
                loaded_q <= 1'b1;
            end

            pending_q <= pending_q & (port_ack ^ req_q);

            if (issue_en) begin
                req_q     <= ~req_q;
                pending_q <= '1;
                a_q       <= issue_addr[ADDR_W-1:1];
                ds_q      <= {issue_addr[0], ~issue_addr[0]};
                d_q       <= {issue_data, issue_data};
            end

            unique case (state_q)
                LD_IDLE: begin
                    if (issue_en) begin
                        state_q <= LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    if (pending_q == '0) begin
                        // Slot drains this cycle; a strobe arriving now refills it.
                        if (slot_full_q) begin
                            slot_full_q <= strb_q;
                            slot_addr_q <= strb_addr_q;
                            slot_data_q <= strb_data_q;
                        end else if (!strb_q) begin
                            state_q <= LD_IDLE;
                        end
                    end else if (strb_q) begin
                        if (slot_full_q) begin
                            overflow_q <= 1'b1;
                        end else begin
                            slot_full_q <= 1'b1;
                            slot_addr_q <= strb_addr_q;
                            slot_data_q <= strb_data_q;
                        end
                    end
                end
                default: state_q <= LD_IDLE;
            endcase
        end
    end

    reset_hold_ctr #(
        .HOLD_W     (HOLD_W),
        .RESET_HOLD (RESET_HOLD)
    ) u_reset_hold_ctr (
        .clk_i        (clk_sys),
        .rst_ni       (reset_n),
        .hold_i       (reset_req || !loaded_q || ioctl_downl),
        .core_reset_o (core_reset)
    );

    assign ioctl_wait = slot_full_q;
    assign port_req   = req_q;
    assign port_a     = a_q;
    assign port_ds    = ds_q;
    assign port_d     = d_q;
    assign port_we    = we_q;
    assign rom_loaded = loaded_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_arcade_rom_loader.sv
// Self-checking bench for arcade_rom_loader: directed handshake/reset cases
// plus a randomized byte stream compared against an ordered write queue.
module tb_arcade_rom_loader;

    localparam int unsigned NP   = 2;
    localparam int unsigned AW   = 24;
    localparam int unsigned HOLD = 16;

    logic            clk_sys = 1'b0;
    logic            reset_n = 1'b0;
    logic            ioctl_downl = 1'b0;
    logic [7:0]      ioctl_index = 8'd0;
    logic            ioctl_wr = 1'b0;
    logic [AW-1:0]   ioctl_addr = '0;
    logic [7:0]      ioctl_dout = '0;
    logic            ioctl_wait;
    logic [NP-1:0]   port_req;
    logic [NP-1:0]   port_ack;
    logic [AW-2:0]   port_a;
    logic [1:0]      port_ds;
    logic [15:0]     port_d;
    logic            port_we;
    logic            reset_req = 1'b0;
    logic            core_reset;
    logic            rom_loaded;
    logic            overflow;

    arcade_rom_loader #(
        .NUM_PORTS  (NP),
        .ADDR_W     (AW),
        .ROM_INDEX  (8'd0),
        .HOLD_W     (16),
        .RESET_HOLD (16'(HOLD))
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_downl (ioctl_downl),
        .ioctl_index (ioctl_index),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wait  (ioctl_wait),
        .port_req    (port_req),
        .port_ack    (port_ack),
        .port_a      (port_a),
        .port_ds     (port_ds),
        .port_d      (port_d),
        .port_we     (port_we),
        .reset_req   (reset_req),
        .core_reset  (core_reset),
        .rom_loaded  (rom_loaded),
        .overflow    (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int unsigned cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected SDRAM writes, in issue order
    typedef struct {
        logic [AW-2:0] a;
        logic [1:0]    ds;
        logic [15:0]   d;
    } wr_t;
    wr_t exp_q[$];

    // Acknowledge responder: each port answers a request after a delay
    bit          ack_hold = 1'b0;
    bit          ack_rand = 1'b0;
    int unsigned ack_dly  = 0;
    int unsigned ack_cnt[NP];
    bit          ack_busy[NP];
    int unsigned last_ack_cyc = 0;

    initial begin
        port_ack = '0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                port_ack = '0;
                for (int i = 0; i < NP; i++) ack_busy[i] = 1'b0;
            end else begin
                for (int i = 0; i < NP; i++) begin
                    if (!ack_busy[i] && port_req[i] != port_ack[i]) begin
                        ack_busy[i] = 1'b1;
                        ack_cnt[i]  = ack_rand ? $urandom_range(0, 6) : ack_dly;
                    end
                    if (ack_busy[i] && !ack_hold) begin
                        if (ack_cnt[i] == 0) begin
                            port_ack[i]  = port_req[i];
                            ack_busy[i]  = 1'b0;
                            last_ack_cyc = cyc;
                        end else begin
                            ack_cnt[i]--;
                        end
                    end
                end
            end
        end
    end

    // Write monitor: each request toggle must match the next expected write,
    // and the write fields must hold until every port has acknowledged.
    int unsigned   toggles = 0;
    int unsigned   last_tog_cyc = 0;
    int unsigned   stab_err = 0;
    logic [NP-1:0] prev_req = '0;
    wr_t           cur;
    wr_t           e;

    initial begin
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                prev_req = '0;
            end else if (port_req != prev_req) begin
                check("req_all_ports", 32'(port_req ^ prev_req), 32'({NP{1'b1}}));
                toggles++;
                last_tog_cyc = cyc;
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("port_a", 32'(port_a), 32'(e.a));
                    check("port_ds", 32'(port_ds), 32'(e.ds));
                    check("port_d", 32'(port_d), 32'(e.d));
                end
                cur.a    = port_a;
                cur.ds   = port_ds;
                cur.d    = port_d;
                prev_req = port_req;
            end else if (port_req != port_ack) begin
                if (port_a != cur.a || port_ds != cur.ds || port_d != cur.d) stab_err++;
            end
        end
    end

    // Caller is just after a negedge; returns two negedges later.
    task automatic strobe(input logic [AW-1:0] addr, input logic [7:0] data, input bit expect_issue);
        wr_t w;
        if (expect_issue) begin
            w.a  = AW'(addr / 2) ;
            w.ds = (addr % 2 == 1) ? 2'b10 : 2'b01;
            w.d  = {data, data};
            exp_q.push_back(w);
        end
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while ((port_req != port_ack || ioctl_wait || exp_q.size() != 0) && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        check(tag, 32'(n < 300), 32'd1);
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned   t0;
        int unsigned   n;
        logic [NP-1:0] req_before;
        logic [AW-1:0] ra;

        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);

        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_rom_loaded", 32'(rom_loaded), 32'd0);
        check("rst_port_req", 32'(port_req), 32'd0);
        check("rst_port_a", 32'(port_a), 32'd0);
        check("rst_port_ds", 32'(port_ds), 32'd0);
        check("rst_port_d", 32'(port_d), 32'd0);
        check("rst_port_we", 32'(port_we), 32'd0);
        check("rst_ioctl_wait", 32'(ioctl_wait), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Single byte, acks three cycles later
        ioctl_downl = 1'b1;
        ioctl_index = 8'd0;
        ack_dly     = 3;
        @(negedge clk_sys);
        @(negedge clk_sys);
        check("we_match", 32'(port_we), 32'd1);
        strobe(24'h000003, 8'hA5, 1'b1);
        check("single_req", 32'(port_req), 32'h3);
        check("single_a", 32'(port_a), 32'h000001);
        check("single_ds", 32'(port_ds), 32'h2);
        check("single_d", 32'(port_d), 32'hA5A5);
        drain("single_drain");
        check("single_ack", 32'(port_ack), 32'h3);

        // Two strobes back to back, acks five cycles later
        ack_dly = 5;
        t0 = toggles;
        strobe(24'h000010, 8'h11, 1'b1);
        strobe(24'h000021, 8'h22, 1'b1);
        check("two_wait_held", 32'(ioctl_wait), 32'd1);
        n = 0;
        while (toggles < t0 + 2 && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        check("two_second_seen", 32'(n < 100), 32'd1);
        // ack driven before edge m, request toggles at edge m+1
        check("two_second_gap", last_tog_cyc - last_ack_cyc, 32'd2);
        check("two_wait_clear", 32'(ioctl_wait), 32'd0);
        check("two_overflow", 32'(overflow), 32'd0);
        drain("two_drain");

        // Three strobes while the first is unacknowledged
        ack_dly    = 2;
        ack_hold   = 1'b1;
        t0         = toggles;
        req_before = port_req;
        strobe(24'h000100, 8'h31, 1'b1);
        strobe(24'h000101, 8'h32, 1'b1);
        strobe(24'h000102, 8'h33, 1'b0);
        repeat (2) @(negedge clk_sys);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_wait", 32'(ioctl_wait), 32'd1);
        ack_hold = 1'b0;
        drain("ovf_drain");
        check("ovf_toggles", toggles - t0, 32'd2);
        check("ovf_req_parity", 32'(port_req), 32'(req_before));
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a transfer
        ack_hold = 1'b1;
        strobe(24'h000200, 8'h44, 1'b1);
        @(negedge clk_sys);
        do_reset();
        ack_hold = 1'b0;
        repeat (8) @(negedge clk_sys);
        check("mid_rst_req", 32'(port_req), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_wait", 32'(ioctl_wait), 32'd0);
        check("mid_rst_a", 32'(port_a), 32'd0);

        // Randomized stream honouring back-pressure
        ack_rand = 1'b1;
        t0 = toggles;
        for (int k = 0; k < 60; k++) begin
            n = 0;
            while (ioctl_wait && n < 100) begin
                @(negedge clk_sys);
                n++;
            end
            check("rand_wait_bound", 32'(n < 100), 32'd1);
            ra = AW'($urandom);
            strobe(ra, 8'($urandom), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk_sys);
        end
        drain("rand_drain");
        check("rand_toggles", toggles - t0, 32'd60);
        check("rand_no_overflow", 32'(overflow), 32'd0);
        check("pre_end_loaded", 32'(rom_loaded), 32'd0);
        check("pre_end_core_reset", 32'(core_reset), 32'd1);

        // End of download and reset release
        ioctl_downl = 1'b0;
        @(negedge clk_sys);
        t0 = cyc;
        check("end_loaded", 32'(rom_loaded), 32'd1);
        check("end_we", 32'(port_we), 32'd0);
        n = 0;
        while (core_reset && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        check("end_core_reset_fall", cyc - t0, 32'(HOLD + 1));

        // User reset pulse
        repeat (3) @(negedge clk_sys);
        reset_req = 1'b1;
        @(negedge clk_sys);
        reset_req = 1'b0;
        t0 = cyc;
        check("ureq_assert", 32'(core_reset), 32'd1);
        n = 0;
        while (core_reset && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        check("ureq_fall", cyc - t0, 32'(HOLD + 1));
        check("ureq_loaded_kept", 32'(rom_loaded), 32'd1);

        // Non-matching index is ignored
        do_reset();
        ioctl_index = 8'd1;
        ioctl_downl = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("nomatch_we", 32'(port_we), 32'd0);
        for (int k = 0; k < 3; k++) strobe(AW'($urandom), 8'($urandom), 1'b0);
        repeat (4) @(negedge clk_sys);
        check("nomatch_req", 32'(port_req), 32'd0);
        ioctl_downl = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("nomatch_loaded", 32'(rom_loaded), 32'd0);
        check("nomatch_core_reset", 32'(core_reset), 32'd1);

        check("fields_stable", stab_err, 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
